snitch_muldiv_unit: RTL and testbench

Integer multiply/divide accelerator that sits behind the Snitch core's accelerator offload port, normally decoupled from it by spill registers on the request and response paths. It accepts one offloaded RV32M instruction with its operands and returns one tagged 32-bit result. At most one operation is in flight at a time. Multiplies complete in one cycle; divides and remainders use a fixed-latency serial divider.

---
 rtl/snitch_muldiv_unit_if.sv | 36 +++
 rtl/snitch_muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_snitch_muldiv_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/snitch_muldiv_unit_if.sv
// Accelerator offload port of the mul/div unit: request and response
// handshake channels bundled into one interface.
interface snitch_muldiv_unit_if #(
  parameter int unsigned IdWidth = 5
);
  // Request channel
  logic [31:0]        acc_qaddr_i;
  logic [IdWidth-1:0] acc_qid_i;
  logic [31:0]        acc_qdata_op_i;
  logic [31:0]        acc_qdata_arga_i;
  logic [31:0]        acc_qdata_argb_i;
  logic [31:0]        acc_qdata_argc_i;
  logic               acc_qvalid_i;
  logic               acc_qready_o;

  // Response channel
  logic [31:0]        acc_pdata_o;
  logic [IdWidth-1:0] acc_pid_o;
  logic               acc_perror_o;
  logic               acc_pvalid_o;
  logic               acc_pready_i;

  // Requester side (core / spill register)
  modport master (
    output acc_qaddr_i, acc_qid_i, acc_qdata_op_i, acc_qdata_arga_i,
           acc_qdata_argb_i, acc_qdata_argc_i, acc_qvalid_i, acc_pready_i,
    input  acc_qready_o, acc_pdata_o, acc_pid_o, acc_perror_o, acc_pvalid_o
  );

  // Accelerator side
  modport slave (
    input  acc_qaddr_i, acc_qid_i, acc_qdata_op_i, acc_qdata_arga_i,
           acc_qdata_argb_i, acc_qdata_argc_i, acc_qvalid_i, acc_pready_i,
    output acc_qready_o, acc_pdata_o, acc_pid_o, acc_perror_o, acc_pvalid_o
  );
endinterface

// File: rtl/snitch_muldiv_unit.sv
// RV32M multiply/divide accelerator. One operation in flight at a time:
// multiplies and illegal ops answer one cycle after acceptance, divides and
// remainders run a 32-step restoring divider on operand magnitudes.
module snitch_muldiv_unit #(
  parameter int unsigned IdWidth = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  snitch_muldiv_unit_if.slave  acc
);

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_DIV  = 2'd1;
  localparam logic [1:0] STATE_RESP = 2'd2;

  logic [1:0]         state_reg, state_next;
  logic [31:0]        pdata_reg;
  logic [IdWidth-1:0] pid_reg;
  logic               perror_reg;

  // Divider datapath state
  logic [31:0] rem_reg;
  logic [31:0] quo_reg;
  logic [31:0] divisor_reg;
  logic [31:0] dividend_reg;
  logic [4:0]  count_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic        is_rem_reg;
  logic        div_zero_reg;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic [31:0] op;
  logic [2:0]  funct3;
  logic        legal;
  logic        accept;
  logic        last_step;

  assign op        = acc.acc_qdata_op_i;
  assign funct3    = op[14:12];
  assign legal     = (op[6:0] == 7'b0110011) && (op[31:25] == 7'b0000001);
  assign accept    = acc.acc_qvalid_i && (state_reg == STATE_IDLE);
  assign last_step = (count_reg == 5'd31);

  // ---------------------------------------------------------------------
  // Single-cycle multiplier: 33-bit sign/zero-extended operands cover all
  // four signedness variants with one signed product.
  // ---------------------------------------------------------------------
  logic               mul_a_signed, mul_b_signed;
  logic signed [32:0] mul_a_ext, mul_b_ext;
  logic signed [65:0] mul_prod;
  logic [31:0]        mul_result;

  assign mul_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010);
  assign mul_b_signed = (funct3 == 3'b001);
  assign mul_a_ext    = {mul_a_signed & acc.acc_qdata_arga_i[31], acc.acc_qdata_arga_i};
  assign mul_b_ext    = {mul_b_signed & acc.acc_qdata_argb_i[31], acc.acc_qdata_argb_i};
  assign mul_prod     = mul_a_ext * mul_b_ext;
  assign mul_result   = (funct3 == 3'b000) ? mul_prod[31:0] : mul_prod[63:32];

  // ---------------------------------------------------------------------
  // Divider setup: magnitudes and result signs. The magnitude of
  // 0x80000000 is itself as an unsigned value, so signed overflow needs no
  // special handling: 2^31 / 1 with a positive quotient sign wraps back to
  // 0x80000000 and leaves remainder 0.
  // ---------------------------------------------------------------------
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  assign div_signed = ~funct3[0];
  assign a_neg      = div_signed & acc.acc_qdata_arga_i[31];
  assign b_neg      = div_signed & acc.acc_qdata_argb_i[31];
  assign a_mag      = a_neg ? -acc.acc_qdata_arga_i : acc.acc_qdata_arga_i;
  assign b_mag      = b_neg ? -acc.acc_qdata_argb_i : acc.acc_qdata_argb_i;

  // ---------------------------------------------------------------------
  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  // ---------------------------------------------------------------------
  logic [32:0] shifted, diff;
  logic        step_bit;
  logic [31:0] rem_step, quo_step, q_final, r_final, div_result;

  assign shifted  = {rem_reg, quo_reg[31]};
  assign diff     = shifted - {1'b0, divisor_reg};
  assign step_bit = ~diff[32];
  assign rem_step = step_bit ? diff[31:0] : shifted[31:0];
  assign quo_step = {quo_reg[30:0], step_bit};
  assign q_final  = neg_q_reg ? -quo_step : quo_step;
  assign r_final  = neg_r_reg ? -rem_step : rem_step;

  // Division by zero is resolved from the latched operands so the signed
  // sign fix-up cannot disturb the architectural result.
  always_comb begin
    div_result = is_rem_reg ? r_final : q_final;
    if (div_zero_reg) begin
      div_result = is_rem_reg ? dividend_reg : 32'hFFFF_FFFF;
    end
  end

  // Next-state selection for the IDLE / DIV / RESP sequencer
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      STATE_IDLE: begin
        if (accept) begin
          state_next = (legal && funct3[2]) ? STATE_DIV : STATE_RESP;
        end
      end
      STATE_DIV: begin
        if (last_step) state_next = STATE_RESP;
      end
      STATE_RESP: begin
        if (acc.acc_pready_i) state_next = STATE_IDLE;
      end
      default: state_next = STATE_IDLE;
    endcase
  end

  // Control state and registered response; response fields only change on
  // acceptance or on divider completion, so they hold under backpressure.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg  <= STATE_IDLE;
      pdata_reg  <= '0;
      pid_reg    <= '0;
      perror_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        pid_reg    <= acc.acc_qid_i;
        perror_reg <= ~legal;
        pdata_reg  <= (legal && !funct3[2]) ? mul_result : 32'h0;
      end else if ((state_reg == STATE_DIV) && last_step) begin
        pdata_reg <= div_result;
      end
    end
  end

  // Divider datapath: loaded on acceptance, stepped once per DIV cycle.
  // Left without reset because the control state gates every use of it.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      rem_reg      <= '0;
      quo_reg      <= a_mag;
      divisor_reg  <= b_mag;
      dividend_reg <= acc.acc_qdata_arga_i;
      count_reg    <= '0;
      neg_q_reg    <= a_neg ^ b_neg;
      neg_r_reg    <= a_neg;
      is_rem_reg   <= funct3[1];
      div_zero_reg <= (acc.acc_qdata_argb_i == 32'h0);
    end else if (state_reg == STATE_DIV) begin
      rem_reg   <= rem_step;
      quo_reg   <= quo_step;
      count_reg <= count_reg + 5'd1;
    end
  end

  assign acc.acc_qready_o = (state_reg == STATE_IDLE);
  assign acc.acc_pvalid_o = (state_reg == STATE_RESP);
  assign acc.acc_pdata_o  = pdata_reg;
  assign acc.acc_pid_o    = pid_reg;
  assign acc.acc_perror_o = perror_reg;

  // Inputs and product bits that carry no information for this unit
  logic unused_sig;
  assign unused_sig = ^{acc.acc_qaddr_i, acc.acc_qdata_argc_i, op[24:15],
                        op[11:7], mul_prod[65:64]};

endmodule

// File: tb/tb_snitch_muldiv_unit.sv
// Directed bench for snitch_muldiv_unit: latency, results, special cases,
// backpressure and mid-operation reset against hand-computed values.
module tb_snitch_muldiv_unit;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;

  int total_cnt = 0;
  int bad_cnt   = 0;

  snitch_muldiv_unit_if #(.IdWidth(5)) acc_if ();

  snitch_muldiv_unit #(.IdWidth(5)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .acc    (acc_if.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] make_op(input logic [2:0] f3);
    return {7'b0000001, 10'h0, f3, 5'h0, 7'b0110011};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one request with pready=1, measure latency, check response and
  // the return to IDLE one cycle after the handshake.
  task automatic run_op(input string name, input logic [31:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] id,
                        input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    int lat;
    acc_if.acc_pready_i     = 1'b1;
    acc_if.acc_qdata_op_i   = op;
    acc_if.acc_qdata_arga_i = a;
    acc_if.acc_qdata_argb_i = b;
    acc_if.acc_qid_i        = id;
    acc_if.acc_qvalid_i     = 1'b1;
    check_val({name, "_qready"}, 32'(acc_if.acc_qready_o), 32'd1);
    tick();
    acc_if.acc_qvalid_i = 1'b0;
    lat = 1;
    while (!acc_if.acc_pvalid_o && lat < 100) begin
      tick();
      lat++;
    end
    check_val({name, "_pvalid"}, 32'(acc_if.acc_pvalid_o), 32'd1);
    check_val({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check_val({name, "_pdata"}, acc_if.acc_pdata_o, exp_data);
    check_val({name, "_pid"}, 32'(acc_if.acc_pid_o), 32'(id));
    check_val({name, "_perror"}, 32'(acc_if.acc_perror_o), 32'(exp_err));
    $display("txn %s a=%h b=%h -> data=%h id=%0d err=%0b lat=%0d",
             name, a, b, acc_if.acc_pdata_o, acc_if.acc_pid_o, acc_if.acc_perror_o, lat);
    tick();
    check_val({name, "_idle_qready"}, 32'(acc_if.acc_qready_o), 32'd1);
    check_val({name, "_idle_pvalid"}, 32'(acc_if.acc_pvalid_o), 32'd0);
  endtask

  initial begin
    int seen;
    acc_if.acc_qaddr_i      = 32'h0;
    acc_if.acc_qid_i        = '0;
    acc_if.acc_qdata_op_i   = 32'h0;
    acc_if.acc_qdata_arga_i = 32'h0;
    acc_if.acc_qdata_argb_i = 32'h0;
    acc_if.acc_qdata_argc_i = 32'hDEAD_BEEF;
    acc_if.acc_qvalid_i     = 1'b0;
    acc_if.acc_pready_i     = 1'b1;

    // Reset state
    repeat (3) tick();
    check_val("rst_pvalid", 32'(acc_if.acc_pvalid_o), 32'd0);
    check_val("rst_perror", 32'(acc_if.acc_perror_o), 32'd0);
    check_val("rst_pdata", acc_if.acc_pdata_o, 32'h0);
    check_val("rst_pid", 32'(acc_if.acc_pid_o), 32'd0);
    rst_ni = 1'b1;
    tick();
    check_val("rst_qready", 32'(acc_if.acc_qready_o), 32'd1);

    // Multiplies
    run_op("mul",    make_op(3'b000), 32'd7,        32'd6,        5'd5,  32'd42,        1'b0, 1);
    run_op("mulh",   make_op(3'b001), 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000,  1'b0, 1);
    run_op("mulhu",  make_op(3'b011), 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE,  1'b0, 1);
    run_op("mulhsu", make_op(3'b010), 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF,  1'b0, 1);

    // Divides and remainders
    run_op("div",    make_op(3'b100), 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD,  1'b0, 33);
    run_op("rem",    make_op(3'b110), 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF,  1'b0, 33);
    run_op("divu",   make_op(3'b101), 32'd100,      32'd7,        5'd7,  32'd14,        1'b0, 33);
    run_op("remu",   make_op(3'b111), 32'd100,      32'd7,        5'd8,  32'd2,         1'b0, 33);
    run_op("div0",   make_op(3'b100), 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF,  1'b0, 33);
    run_op("remu0",  make_op(3'b111), 32'd5,        32'd0,        5'd10, 32'd5,         1'b0, 33);
    run_op("divovf", make_op(3'b100), 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000,  1'b0, 33);
    run_op("removf", make_op(3'b110), 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000,  1'b0, 33);

    // Backpressure: first MUL held for 10 cycles while a second request waits
    acc_if.acc_pready_i     = 1'b0;
    acc_if.acc_qdata_op_i   = make_op(3'b000);
    acc_if.acc_qdata_arga_i = 32'd3;
    acc_if.acc_qdata_argb_i = 32'd4;
    acc_if.acc_qid_i        = 5'd13;
    acc_if.acc_qvalid_i     = 1'b1;
    tick();
    acc_if.acc_qdata_arga_i = 32'd5;
    acc_if.acc_qdata_argb_i = 32'd6;
    acc_if.acc_qid_i        = 5'd14;
    for (int i = 0; i < 10; i++) begin
      check_val("bp_pvalid", 32'(acc_if.acc_pvalid_o), 32'd1);
      check_val("bp_pdata", acc_if.acc_pdata_o, 32'd12);
      check_val("bp_pid", 32'(acc_if.acc_pid_o), 32'd13);
      check_val("bp_qready", 32'(acc_if.acc_qready_o), 32'd0);
      if (i < 9) tick();
    end
    $display("txn bp_first a=3 b=4 -> data=%h id=%0d held 10 cycles", acc_if.acc_pdata_o, acc_if.acc_pid_o);
    acc_if.acc_pready_i = 1'b1;
    tick();
    check_val("bp_rel_qready", 32'(acc_if.acc_qready_o), 32'd1);
    check_val("bp_rel_pvalid", 32'(acc_if.acc_pvalid_o), 32'd0);
    tick();
    acc_if.acc_qvalid_i = 1'b0;
    check_val("bp2_pvalid", 32'(acc_if.acc_pvalid_o), 32'd1);
    check_val("bp2_pdata", acc_if.acc_pdata_o, 32'd30);
    check_val("bp2_pid", 32'(acc_if.acc_pid_o), 32'd14);
    $display("txn bp_second a=5 b=6 -> data=%h id=%0d", acc_if.acc_pdata_o, acc_if.acc_pid_o);
    tick();
    check_val("bp2_idle", 32'(acc_if.acc_qready_o), 32'd1);

    // Illegal op
    run_op("illegal", 32'h00000013, 32'd11, 32'd22, 5'd15, 32'h0, 1'b1, 1);

    // Reset in cycle 10 of a DIV aborts it
    acc_if.acc_qdata_op_i   = make_op(3'b101);
    acc_if.acc_qdata_arga_i = 32'd1000;
    acc_if.acc_qdata_argb_i = 32'd3;
    acc_if.acc_qid_i        = 5'd16;
    acc_if.acc_qvalid_i     = 1'b1;
    tick();
    acc_if.acc_qvalid_i = 1'b0;
    repeat (9) tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check_val("abort_pvalid", 32'(acc_if.acc_pvalid_o), 32'd0);
    check_val("abort_qready", 32'(acc_if.acc_qready_o), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (acc_if.acc_pvalid_o) seen++;
      tick();
    end
    check_val("abort_no_resp", 32'(seen), 32'd0);
    $display("txn abort_divu a=1000 b=3 -> responses seen=%0d", seen);

    // Unit still usable after the abort
    run_op("post_rst", make_op(3'b101), 32'd1000, 32'd3, 5'd17, 32'd333, 1'b0, 33);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
